// File: rtl/dcca_ce_sequencer.sv
// dcca_ce_sequencer: drives the CE pin of a DCCA clock buffer.
// Stop gates only after an idle drain; start reports running after settling.
module dcca_ce_sequencer #(
   parameter int STOP_DELAY  = 4,
   parameter int START_DELAY = 3,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stop_req,
   input  logic       start_req,
   input  logic       busy,
   output logic       ce,
   output logic       running,
   output logic       stop_ack,
   output logic       start_ack,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_DRAIN   = 2'd1,
      S_STOPPED = 2'd2,
      S_WAKE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_DELAY - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DELAY - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stop_pend;
   logic             r_ce;
   logic             r_running;
   logic             r_stop_ack;
   logic             r_start_ack;

   // Sequencer FSM: every output is a register so CE never sees input glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_cnt       <= '0;
         r_stop_pend <= 1'b0;
         r_ce        <= 1'b1;
         r_running   <= 1'b1;
         r_stop_ack  <= 1'b0;
         r_start_ack <= 1'b0;
      end else begin
         r_stop_ack  <= 1'b0;
         r_start_ack <= 1'b0;
         unique case (r_state)
            S_RUN: begin
               if (start_req) begin
                  r_start_ack <= 1'b1;
               end else if (stop_req) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= '0;
               end
            end
            S_DRAIN: begin
               if (start_req) begin
                  r_state     <= S_RUN;
                  r_start_ack <= 1'b1;
                  r_cnt       <= '0;
               end else if (busy) begin
                  r_cnt <= '0;
               end else if (r_cnt == STOP_LAST) begin
                  r_state    <= S_STOPPED;
                  r_ce       <= 1'b0;
                  r_running  <= 1'b0;
                  r_stop_ack <= 1'b1;
                  r_cnt      <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOPPED: begin
               if (start_req) begin
                  r_state <= S_WAKE;
                  r_ce    <= 1'b1;
                  r_cnt   <= '0;
               end else if (stop_req) begin
                  r_stop_ack <= 1'b1;
               end
            end
            S_WAKE: begin
               if (r_cnt == START_LAST) begin
                  r_running   <= 1'b1;
                  r_start_ack <= 1'b1;
                  r_cnt       <= '0;
                  r_stop_pend <= 1'b0;
                  if (r_stop_pend || stop_req) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_state <= S_RUN;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (stop_req) begin
                     r_stop_pend <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign ce        = r_ce;
   assign running   = r_running;
   assign stop_ack  = r_stop_ack;
   assign start_ack = r_start_ack;
   assign state_o   = r_state;

endmodule

// File: tb/tb_dcca_ce_sequencer.sv
// tb_dcca_ce_sequencer: directed and random checks of the CE sequencer
// against a cycle-level reference model of the stop/start rules.
module tb_dcca_ce_sequencer;

   localparam int STOP_DELAY  = 4;
   localparam int START_DELAY = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stop_req = 1'b0;
   logic       start_req = 1'b0;
   logic       busy = 1'b0;
   logic       ce;
   logic       running;
   logic       stop_ack;
   logic       start_ack;
   logic [1:0] state_o;

   int n_chk  = 0;
   int n_pass = 0;

   dcca_ce_sequencer #(
      .STOP_DELAY (STOP_DELAY),
      .START_DELAY(START_DELAY),
      .CNT_W      (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .stop_req (stop_req),
      .start_req(start_req),
      .busy     (busy),
      .ce       (ce),
      .running  (running),
      .stop_ack (stop_ack),
      .start_ack(start_ack),
      .state_o  (state_o)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 RUN, 1 DRAIN, 2 STOPPED, 3 WAKE.
   int m_mode = 0;
   int m_idle = 0;
   int m_wait = 0;
   bit m_pend = 0;
   bit m_sack = 0;
   bit m_tack = 0;

   function automatic logic [5:0] exp_vec();
      logic e_ce, e_run;
      e_ce  = (m_mode != 2);
      e_run = (m_mode == 0) || (m_mode == 1);
      return {e_ce, e_run, m_sack, m_tack, 2'(m_mode)};
   endfunction

   function automatic logic [5:0] dut_vec();
      return {ce, running, stop_ack, start_ack, state_o};
   endfunction

   task automatic model_step();
      m_sack = 0;
      m_tack = 0;
      if (rst) begin
         m_mode = 0;
         m_pend = 0;
         return;
      end
      case (m_mode)
         0: begin
            if (start_req) m_tack = 1;
            else if (stop_req) begin
               m_mode = 1;
               m_idle = 0;
            end
         end
         1: begin
            if (start_req) begin
               m_mode = 0;
               m_tack = 1;
            end else if (busy) m_idle = 0;
            else begin
               m_idle++;
               if (m_idle >= STOP_DELAY) begin
                  m_mode = 2;
                  m_sack = 1;
               end
            end
         end
         2: begin
            if (start_req) begin
               m_mode = 3;
               m_wait = 0;
            end else if (stop_req) m_sack = 1;
         end
         default: begin
            if (stop_req) m_pend = 1;
            m_wait++;
            if (m_wait >= START_DELAY) begin
               m_tack = 1;
               if (m_pend) begin
                  m_mode = 1;
                  m_idle = 0;
               end else m_mode = 0;
               m_pend = 0;
            end
         end
      endcase
   endtask

   // One clock: drive, let the edge sample, update model, settle.
   task automatic tick(input logic s, input logic t, input logic b);
      stop_req  = s;
      start_req = t;
      busy      = b;
      @(posedge clk);
      model_step();
      #1;
      stop_req  = 1'b0;
      start_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(0, 0, 0);
      tick(0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(0, 0, 0);
         n_chk++;
         if (dut_vec() !== 6'b110000)
            $display("FAIL reset_idle[%0d] got %b want %b", i, dut_vec(), 6'b110000);
         else n_pass++;
      end
   endtask

   task automatic test_clean_stop();
      int ack_at, acks;
      ack_at = -1;
      acks   = 0;
      tick(1, 0, 0);
      n_chk++;
      if (state_o !== 2'd1)
         $display("FAIL stop_enter_drain got %0d want 1", state_o);
      else n_pass++;
      for (int i = 1; i < 12; i++) begin
         tick(0, 0, 0);
         if (stop_ack) begin
            acks++;
            if (ack_at < 0) ack_at = i;
         end
         n_chk++;
         if (dut_vec() !== exp_vec())
            $display("FAIL clean_stop[%0d] got %b want %b", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_chk++;
      if (ack_at !== STOP_DELAY || acks !== 1)
         $display("FAIL clean_stop_latency got idx %0d n %0d want idx %0d n 1",
                  ack_at, acks, STOP_DELAY);
      else n_pass++;
   endtask

   task automatic test_start();
      int run_at;
      run_at = -1;
      tick(0, 1, 0);
      n_chk++;
      if ({ce, running, state_o} !== 4'b1011)
         $display("FAIL start_wake got %b want 1011", {ce, running, state_o});
      else n_pass++;
      for (int i = 1; i < 8; i++) begin
         tick(0, 1, 0);
         if (start_ack && run_at < 0) run_at = i;
         n_chk++;
         if (dut_vec() !== exp_vec())
            $display("FAIL start[%0d] got %b want %b", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_chk++;
      if (run_at !== START_DELAY)
         $display("FAIL start_latency got %0d want %0d", run_at, START_DELAY);
      else n_pass++;
   endtask

   task automatic test_busy_drain();
      int ack_at, acks;
      ack_at = -1;
      acks   = 0;
      tick(1, 0, 0);
      for (int i = 1; i < 14; i++) begin
         tick(0, 0, (i == 2 || i == 3));
         if (stop_ack) begin
            acks++;
            if (ack_at < 0) ack_at = i;
         end
         n_chk++;
         if (dut_vec() !== exp_vec())
            $display("FAIL busy_drain[%0d] got %b want %b", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_chk++;
      if (ack_at !== STOP_DELAY + 3 || acks !== 1)
         $display("FAIL busy_latency got idx %0d n %0d want idx %0d n 1",
                  ack_at, acks, STOP_DELAY + 3);
      else n_pass++;
   endtask

   task automatic test_abort();
      bit ce_dropped;
      ce_dropped = 0;
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 1, 0);
      n_chk++;
      if ({state_o, start_ack, stop_ack} !== 4'b0010)
         $display("FAIL abort got %b want 0010", {state_o, start_ack, stop_ack});
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 0);
         if (!ce) ce_dropped = 1;
      end
      n_chk++;
      if (ce_dropped)
         $display("FAIL abort_ce got dropped want held");
      else n_pass++;
   endtask

   task automatic test_collision();
      tick(1, 1, 0);
      n_chk++;
      if ({state_o, stop_ack, start_ack} !== 4'b0001)
         $display("FAIL collision got %b want 0001", {state_o, stop_ack, start_ack});
      else n_pass++;
      tick(0, 0, 0);
      n_chk++;
      if (dut_vec() !== exp_vec())
         $display("FAIL collision_after got %b want %b", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_pending_stop();
      int tack_at, sack_at;
      tack_at = -1;
      sack_at = -1;
      tick(1, 0, 0);
      for (int i = 0; i < STOP_DELAY + 1; i++) tick(0, 0, 0);
      tick(0, 1, 0);
      tick(1, 0, 0);
      for (int i = 0; i < 14; i++) begin
         tick(0, 0, 0);
         if (start_ack && tack_at < 0) tack_at = i;
         if (stop_ack && sack_at < 0) sack_at = i;
         n_chk++;
         if (dut_vec() !== exp_vec())
            $display("FAIL pend[%0d] got %b want %b", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_chk++;
      if (tack_at < 0 || sack_at - tack_at !== STOP_DELAY)
         $display("FAIL pend_latency got tack %0d sack %0d want gap %0d",
                  tack_at, sack_at, STOP_DELAY);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      tick(1, 0, 0);
      for (int i = 0; i < STOP_DELAY + 1; i++) tick(0, 0, 0);
      n_chk++;
      if (state_o !== 2'd2)
         $display("FAIL rstmid_pre got %0d want 2", state_o);
      else n_pass++;
      rst = 1'b1;
      tick(0, 0, 0);
      rst = 1'b0;
      n_chk++;
      if (dut_vec() !== 6'b110000)
         $display("FAIL rstmid got %b want 110000", dut_vec());
      else n_pass++;
   endtask

   task automatic test_random();
      logic s, t, b;
      for (int i = 0; i < 1500; i++) begin
         s = ($urandom_range(0, 9) == 0);
         t = ($urandom_range(0, 11) == 0);
         b = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 199) == 0);
         tick(s, t, b);
         n_chk++;
         if (dut_vec() !== exp_vec())
            $display("FAIL random[%0d] got %b want %b", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_stop();
      test_start();
      test_busy_drain();
      test_start();
      test_abort();
      test_collision();
      test_pending_stop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
